retune_sequencer: RTL and testbench



---
 rtl/retune_sequencer_pkg.sv | 31 +++
 rtl/retune_sequencer_phase_shadow_bank.sv | 60 ++++++
 rtl/retune_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_retune_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/retune_sequencer_pkg.sv
// Shared types and cfg-bus layout for the retune sequencer.
// The control byte positions live here so the top and any consumers agree on them.
package retune_sequencer_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StBlank  = 3'd1,
      StReset  = 3'd2,
      StLoad   = 3'd3,
      StSettle = 3'd4,
      StRun    = 3'd5
   } state_t;

   localparam int unsigned RSTN_BIT     = 0;
   localparam int unsigned BLANK_BIT    = 8;
   localparam int unsigned PHASEVLD_BIT = 16;
   localparam int unsigned CTRL_WIDTH   = PHASEVLD_BIT + 1;

   // Control field of cfg word 0; the remaining bits of that word are zero.
   function automatic logic [CTRL_WIDTH-1:0] ctrl_bits(input logic rstn,
                                                       input logic blank,
                                                       input logic phasevld);
      logic [CTRL_WIDTH-1:0] w_bits;
      w_bits               = '0;
      w_bits[RSTN_BIT]     = rstn;
      w_bits[BLANK_BIT]    = blank;
      w_bits[PHASEVLD_BIT] = phasevld;
      return w_bits;
   endfunction

endpackage

// File: rtl/retune_sequencer_phase_shadow_bank.sv
// Shadow and active phase-increment registers: writes land in shadow at any time,
// the whole shadow set is copied to active in one edge when i_load is high.
module retune_sequencer_phase_shadow_bank #(
   parameter int unsigned NUM_CHANS   = 13,
   parameter int unsigned PHASE_WIDTH = 32
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             i_wr_en,
   input  logic [3:0]                       i_wr_chan,
   input  logic [PHASE_WIDTH-1:0]           i_wr_phase,
   input  logic                             i_load,
   output logic [NUM_CHANS*PHASE_WIDTH-1:0] o_active,
   output logic                             o_wr_err
);

   logic [PHASE_WIDTH-1:0] r_shadow [NUM_CHANS];
   logic [PHASE_WIDTH-1:0] r_active [NUM_CHANS];
   logic                   r_wr_err;
   logic                   w_chan_ok;

   assign w_chan_ok = (32'(i_wr_chan) < NUM_CHANS);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < NUM_CHANS; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_CHANS; i++) begin
            if (i_wr_en && (32'(i_wr_chan) == i)) begin
               r_shadow[i] <= i_wr_phase;
            end
            // Old shadow value is copied; a write in the same edge waits for the next load.
            if (i_load) begin
               r_active[i] <= r_shadow[i];
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_err <= 1'b0;
      end else if (i_wr_en && !w_chan_ok) begin
         r_wr_err <= 1'b1;
      end
   end

   always_comb begin
      o_active = '0;
      for (int unsigned i = 0; i < NUM_CHANS; i++) begin
         o_active[i*PHASE_WIDTH +: PHASE_WIDTH] = r_active[i];
      end
   end

   assign o_wr_err = r_wr_err;

endmodule

// File: rtl/retune_sequencer.sv
// Channelizer retune controller: applies shadowed phase increments via blank/reset/load/settle.
// Optional: define RETUNE_COUNT_EN to add the saturating retune_cnt[15:0] output.
module retune_sequencer #(
   parameter int unsigned NUM_CHANS     = 13,
   parameter int unsigned PHASE_WIDTH   = 32,
   parameter int unsigned CFG_WIDTH     = (NUM_CHANS + 1) * PHASE_WIDTH,
   parameter int unsigned BLANK_CYCLES  = 16,
   parameter int unsigned RST_CYCLES    = 32,
   parameter int unsigned SETTLE_CYCLES = 4096,
   parameter int unsigned CNT_WIDTH     = 24
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   wr_en,
   input  logic [3:0]             wr_chan,
   input  logic [PHASE_WIDTH-1:0] wr_phase,
   input  logic                   commit,
   output logic [CFG_WIDTH-1:0]   cfg_out,
   output logic                   busy,
   output logic                   done,
   output logic                   wr_err
`ifdef RETUNE_COUNT_EN
   ,
   output logic [15:0]            retune_cnt
`endif
);
   import retune_sequencer_pkg::*;

   localparam logic [CNT_WIDTH-1:0] BLANK_LOAD  = CNT_WIDTH'(BLANK_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] RST_LOAD    = CNT_WIDTH'(RST_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);

   state_t                         r_state;
   state_t                         w_state_nxt;
   logic [CNT_WIDTH-1:0]           r_cnt;
   logic [CNT_WIDTH-1:0]           w_cnt_nxt;
   logic                           w_cnt_zero;
   logic                           r_pending;
   logic                           w_pending_nxt;
   logic                           r_rstn;
   logic                           r_blank;
   logic                           r_phasevld;
   logic                           r_busy;
   logic                           r_done;
   logic                           w_rstn_nxt;
   logic                           w_blank_nxt;
   logic                           w_phasevld_nxt;
   logic                           w_busy_nxt;
   logic                           w_done_nxt;
   logic                           w_load;
   logic [NUM_CHANS*PHASE_WIDTH-1:0] w_active;

   assign w_cnt_zero = (r_cnt == '0);
   assign w_load     = (w_state_nxt == StLoad);

   // State, counter, pending flag and the registered cfg control bits.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_pending  <= 1'b0;
         r_rstn     <= 1'b0;
         r_blank    <= 1'b1;
         r_phasevld <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_pending  <= w_pending_nxt;
         r_rstn     <= w_rstn_nxt;
         r_blank    <= w_blank_nxt;
         r_phasevld <= w_phasevld_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_pending_nxt = r_pending;
      unique case (r_state)
         StIdle: begin
            if (commit) begin
               w_state_nxt = StBlank;
               w_cnt_nxt   = BLANK_LOAD;
            end
         end
         StBlank: begin
            if (w_cnt_zero) begin
               w_state_nxt = StReset;
               w_cnt_nxt   = RST_LOAD;
            end else begin
               w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
            end
         end
         StReset: begin
            if (w_cnt_zero) begin
               w_state_nxt = StLoad;
            end else begin
               w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
            end
         end
         StLoad: begin
            w_state_nxt = StSettle;
            w_cnt_nxt   = SETTLE_LOAD;
         end
         StSettle: begin
            if (w_cnt_zero) begin
               w_state_nxt = StRun;
            end else begin
               w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
            end
         end
         StRun: begin
            if (commit || r_pending) begin
               w_state_nxt   = StBlank;
               w_cnt_nxt     = BLANK_LOAD;
               w_pending_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
      // Commits during a sequence collapse into one restart after RUN.
      if (commit && (r_state != StIdle) && (r_state != StRun)) begin
         w_pending_nxt = 1'b1;
      end
   end

   // Control bits are decoded from the next state so they change with the state register.
   always_comb begin
      w_rstn_nxt = r_rstn;
      unique case (w_state_nxt)
         StReset, StLoad:  w_rstn_nxt = 1'b0;
         StSettle, StRun:  w_rstn_nxt = 1'b1;
         default:          w_rstn_nxt = r_rstn;
      endcase
      w_blank_nxt    = (w_state_nxt != StRun);
      w_phasevld_nxt = (w_state_nxt == StLoad);
      w_busy_nxt     = (w_state_nxt != StIdle) && (w_state_nxt != StRun);
      w_done_nxt     = (w_state_nxt == StRun) && (r_state != StRun);
   end

   retune_sequencer_phase_shadow_bank #(
      .NUM_CHANS   (NUM_CHANS),
      .PHASE_WIDTH (PHASE_WIDTH)
   ) u_bank (
      .i_clk      (aclk),
      .i_rst      (areset),
      .i_wr_en    (wr_en),
      .i_wr_chan  (wr_chan),
      .i_wr_phase (wr_phase),
      .i_load     (w_load),
      .o_active   (w_active),
      .o_wr_err   (wr_err)
   );

   always_comb begin
      cfg_out                              = '0;
      cfg_out[PHASE_WIDTH-1:0]             = PHASE_WIDTH'(ctrl_bits(r_rstn, r_blank, r_phasevld));
      cfg_out[CFG_WIDTH-1:PHASE_WIDTH]     = w_active;
   end

   assign busy = r_busy;
   assign done = r_done;

`ifdef RETUNE_COUNT_EN
   logic [15:0] r_retune_cnt;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_retune_cnt <= '0;
      end else if (w_done_nxt && (r_retune_cnt != 16'hFFFF)) begin
         r_retune_cnt <= r_retune_cnt + 16'd1;
      end
   end

   assign retune_cnt = r_retune_cnt;
`endif

endmodule

// File: tb/tb_retune_sequencer.sv
// Scoreboard bench for retune_sequencer: stimulus queues expected done events,
// a monitor pops and compares them whenever done is seen.
module tb_retune_sequencer;

   localparam int NCH = 13;
   localparam int PW  = 32;
   localparam int CW  = (NCH + 1) * PW;
   localparam int LAT = 4146;

   logic          aclk     = 1'b0;
   logic          areset   = 1'b1;
   logic          wr_en    = 1'b0;
   logic [3:0]    wr_chan  = 4'd0;
   logic [PW-1:0] wr_phase = '0;
   logic          commit   = 1'b0;
   logic [CW-1:0] cfg_out;
   logic          busy;
   logic          done;
   logic          wr_err;
`ifdef RETUNE_COUNT_EN
   logic [15:0]   retune_cnt;
`endif

   retune_sequencer dut (
      .aclk     (aclk),
      .areset   (areset),
      .wr_en    (wr_en),
      .wr_chan  (wr_chan),
      .wr_phase (wr_phase),
      .commit   (commit),
      .cfg_out  (cfg_out),
      .busy     (busy),
      .done     (done),
      .wr_err   (wr_err)
`ifdef RETUNE_COUNT_EN
      ,
      .retune_cnt (retune_cnt)
`endif
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   typedef struct {
      int            cyc;
      logic [CW-1:0] cfg;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   logic [PW-1:0] m_shadow [NCH];
   int            n_checks = 0;
   int            n_errors = 0;
   int            n_done_model = 0;
   int            k = 0;
   int            c_base = 0;

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [NCH*PW-1:0] flat_shadow();
      logic [NCH*PW-1:0] v;
      v = '0;
      for (int i = 0; i < NCH; i++) v[i*PW +: PW] = m_shadow[i];
      return v;
   endfunction

   function automatic logic [CW-1:0] mk_cfg(input logic rstn, input logic blank, input logic pv,
                                            input logic [NCH*PW-1:0] ph);
      logic [CW-1:0] v;
      v         = '0;
      v[0]      = rstn;
      v[8]      = blank;
      v[16]     = pv;
      v[CW-1:PW] = ph;
      return v;
   endfunction

   task automatic step();
      @(negedge aclk);
      k++;
   endtask

   task automatic run_to(input int target);
      while (k < target) step();
   endtask

   // Drives a write for one cycle; the model ignores out-of-range channels.
   task automatic do_write(input int ch, input logic [PW-1:0] ph);
      wr_en    = 1'b1;
      wr_chan  = 4'(ch);
      wr_phase = ph;
      if (ch < NCH) m_shadow[ch] = ph;
      step();
      wr_en = 1'b0;
   endtask

   task automatic push_done(input int c);
      sb.push_back('{cyc: c, cfg: mk_cfg(1'b1, 1'b0, 1'b0, flat_shadow())});
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   initial begin
      forever begin
         @(negedge aclk);
         if (!areset && done) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
               mon_e = sb.pop_front();
               check("done_cycle", CW'(cyc), CW'(mon_e.cyc));
               check("done_cfg", cfg_out, mon_e.cfg);
               check("done_busy", CW'(busy), '0);
`ifdef RETUNE_COUNT_EN
               n_done_model++;
               check("retune_cnt", CW'(retune_cnt), CW'(n_done_model));
`endif
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < NCH; i++) m_shadow[i] = '0;

      // Reset values
      repeat (3) @(negedge aclk);
      check("rst_cfg", cfg_out, mk_cfg(1'b0, 1'b1, 1'b0, '0));
      check("rst_busy", CW'(busy), '0);
      check("rst_done", CW'(done), '0);
      check("rst_wr_err", CW'(wr_err), '0);
      areset = 1'b0;
      repeat (2) @(negedge aclk);
      check("idle_cfg", cfg_out, mk_cfg(1'b0, 1'b1, 1'b0, '0));

      // Basic commit; ch12 write shares the commit cycle
      do_write(0, 32'h0A3D70A4);
      wr_en    = 1'b1;
      wr_chan  = 4'd12;
      wr_phase = 32'h40000000;
      m_shadow[12] = 32'h40000000;
      commit   = 1'b1;
      c_base   = cyc;
      push_done(c_base + LAT);
      k = 0;
      step();
      wr_en  = 1'b0;
      commit = 1'b0;
      check("t2_blank_k1", CW'(cfg_out[8]), CW'(1));
      check("t2_busy_k1", CW'(busy), CW'(1));
      run_to(16);
      check("t2_rstn_k16", CW'(cfg_out[0]), '0);
      run_to(17);
      check("t2_rstn_k17", CW'(cfg_out[0]), '0);
      run_to(48);
      check("t2_k48_cfg", cfg_out, mk_cfg(1'b0, 1'b1, 1'b0, '0));
      run_to(49);
      check("t2_load_cfg", cfg_out, mk_cfg(1'b0, 1'b1, 1'b1, flat_shadow()));
      run_to(50);
      check("t2_settle_cfg", cfg_out, mk_cfg(1'b1, 1'b1, 1'b0, flat_shadow()));
      run_to(LAT - 1);
      check("t2_pre_done", CW'(done), '0);
      check("t2_pre_blank", CW'(cfg_out[8]), CW'(1));
      run_to(LAT);
      check("t2_run_blank", CW'(cfg_out[8]), '0);
      run_to(LAT + 1);
      check("t2_done_pulse", CW'(done), '0);
      check("t2_run_cfg", cfg_out, mk_cfg(1'b1, 1'b0, 1'b0, flat_shadow()));

      // Two commits during SETTLE plus a write: one restart, second LOAD picks up the write
      do_write(0, 32'h11111111);
      commit = 1'b1;
      c_base = cyc;
      push_done(c_base + LAT);
      k = 0;
      step();
      commit = 1'b0;
      check("t3_rstn_hold", CW'(cfg_out[0]), CW'(1));
      run_to(100);
      commit = 1'b1;
      step();
      commit = 1'b0;
      run_to(200);
      do_write(12, 32'h22222222);
      run_to(300);
      commit = 1'b1;
      push_done(c_base + 2 * LAT);
      step();
      commit = 1'b0;
      run_to(LAT + 1);
      check("t3_restart_busy", CW'(busy), CW'(1));
      run_to(2 * LAT + 2);
      check("t3_final_busy", CW'(busy), '0);

      // Out-of-range write is dropped and sticky
      check("t4_err_before", CW'(wr_err), '0);
      do_write(13, 32'hDEADBEEF);
      check("t4_err_set", CW'(wr_err), CW'(1));
      do_write(5, 32'h55555555);
      check("t4_err_sticky", CW'(wr_err), CW'(1));
      commit = 1'b1;
      c_base = cyc;
      push_done(c_base + LAT);
      k = 0;
      step();
      commit = 1'b0;
      run_to(LAT + 2);

      // Asynchronous reset mid-sequence
      commit = 1'b1;
      k = 0;
      step();
      commit = 1'b0;
      run_to(30);
      check("t5_rstn_k30", CW'(cfg_out[0]), '0);
      areset = 1'b1;
      #1;
      check("t5_async_cfg", cfg_out, mk_cfg(1'b0, 1'b1, 1'b0, '0));
      check("t5_async_busy", CW'(busy), '0);
      check("t5_async_err", CW'(wr_err), '0);
      for (int i = 0; i < NCH; i++) m_shadow[i] = '0;
      n_done_model = 0;
      repeat (2) @(negedge aclk);
      areset = 1'b0;
      repeat (2) @(negedge aclk);
      check("t5_idle_busy", CW'(busy), '0);
      commit = 1'b1;
      c_base = cyc;
      push_done(c_base + LAT);
      k = 0;
      step();
      commit = 1'b0;
      run_to(LAT + 3);

      check("sb_empty", CW'(sb.size()), '0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
